// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register, 2-entry skid buffer (SKID=1) or 1-entry stage (SKID=0).
module pipe_stage_reg #(
    parameter int               WIDTH     = 32,
    parameter int               SKID      = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    logic push;
    logic pop;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    generate
        if (SKID != 0) begin : g_skid
            state_t           state;
            state_t           state_next;
            logic [WIDTH-1:0] head;
            logic [WIDTH-1:0] skid;
            logic             ready_q;

            always_comb begin
                state_next = state;
                case (state)
                    EMPTY:   state_next = push ? ONE : EMPTY;
                    ONE:     state_next = (push && !pop) ? FULL : (pop && !push) ? EMPTY : ONE;
                    FULL:    state_next = pop ? ONE : FULL;
                    default: state_next = EMPTY;
                endcase
                if (flush)
                    state_next = EMPTY;
            end

            // ready is the registered image of "not full after this edge"
            always_ff @(posedge clk) begin
                if (!rst) begin
                    state   <= EMPTY;
                    head    <= RESET_VAL;
                    skid    <= '0;
                    ready_q <= 1'b0;
                end else begin
                    state   <= state_next;
                    ready_q <= (state_next != FULL);
                    if (!flush) begin
                        if (state == FULL && pop)
                            head <= skid;
                        else if (push && (state == EMPTY || pop))
                            head <= in_data;
                        if (push && state == ONE && !pop)
                            skid <= in_data;
                    end
                end
            end

            assign in_ready  = ready_q;
            assign out_valid = (state != EMPTY);
            assign out_data  = head;
            assign count     = state;
        end else begin : g_pass
            logic             valid_q;
            logic             alive;
            logic [WIDTH-1:0] data_q;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    valid_q <= 1'b0;
                    alive   <= 1'b0;
                    data_q  <= RESET_VAL;
                end else begin
                    alive <= 1'b1;
                    if (flush)
                        valid_q <= 1'b0;
                    else if (push) begin
                        valid_q <= 1'b1;
                        data_q  <= in_data;
                    end else if (pop)
                        valid_q <= 1'b0;
                end
            end

            // alive holds ready low through reset and until the first edge out of it
            assign in_ready  = alive && (!valid_q || out_ready);
            assign out_valid = valid_q;
            assign out_data  = data_q;
            assign count     = {1'b0, valid_q};
        end
    endgenerate

endmodule
